// File: rtl/lp805x_sfrmaster.sv
// -----------------------------------------------------------------------------
// lp805x_sfrmaster
//   CPU-side initiator for the lp805x clock-crossing SFR bus. Takes one byte or
//   bit read/write request at a time from the core's SFR access stage, packs it
//   into the 29-bit sfr_bus word, pushes it to the peripheral synchroniser and,
//   for reads, pops and captures the response. Responses arriving while no read
//   is outstanding are drained and counted. All outputs are registered.
//
// Ports
//   clk        in   CPU clock
//   rst        in   synchronous active-low reset
//   req_valid  in   request strobe, qualified by req_ready
//   req_ready  out  high only while idle
//   req_wr     in   write select
//   req_rd     in   read select
//   req_bit    in   1 = bit access, 0 = byte access
//   req_addr   in   [7:0] SFR address or bit address
//   req_wdata  in   [7:0] write byte
//   req_wbit   in   write bit
//   rsp_valid  out  one-cycle completion pulse
//   rsp_err    out  read timeout or wr+rd conflict, valid with rsp_valid
//   rsp_data   out  [7:0] read byte, held until the next read completes
//   rsp_bit    out  read bit, held until the next read completes
//   sfr_bus    out  [28:0] {wr, rd, wr_bit, rd_bit, wr_addr, rd_addr, data, bit}
//   sfr_put    out  push strobe to the synchroniser
//   sfr_wrdy   in   synchroniser can accept a word
//   sfr_rrdy   in   a response is available
//   sfr_get    out  pop strobe for the response
//   data_out   in   [7:0] response byte, valid while sfr_get is high
//   bit_out    in   response bit, valid while sfr_get is high
//   drop_cnt   out  [7:0] stale responses discarded, saturating
// -----------------------------------------------------------------------------
module lp805x_sfrmaster #(
   parameter int          TIMEOUT   = 16,
   parameter int          TO_W      = 5,
   parameter logic [7:0]  IDLE_ADDR = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic        req_rd,
   input  logic        req_bit,
   input  logic [7:0]  req_addr,
   input  logic [7:0]  req_wdata,
   input  logic        req_wbit,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [7:0]  rsp_data,
   output logic        rsp_bit,
   output logic [28:0] sfr_bus,
   output logic        sfr_put,
   input  logic        sfr_wrdy,
   input  logic        sfr_rrdy,
   output logic        sfr_get,
   input  logic [7:0]  data_out,
   input  logic        bit_out,
   output logic [7:0]  drop_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_PUT, S_WAIT, S_DONE} state_t;

   typedef struct packed {
      logic       wr;
      logic       rd;
      logic       wr_bit;
      logic       rd_bit;
      logic [7:0] wr_addr;
      logic [7:0] rd_addr;
      logic [7:0] data;
      logic       wbit;
   } sfr_word_t;

   // Peripherals decode rd_addr without looking at rd, so both address fields
   // must point at an address nobody owns while the bus is idle.
   localparam sfr_word_t IDLE_WORD = '{wr: 1'b0, rd: 1'b0, wr_bit: 1'b0, rd_bit: 1'b0,
                                       wr_addr: IDLE_ADDR, rd_addr: IDLE_ADDR,
                                       data: 8'h00, wbit: 1'b0};

   state_t          r_state,    w_state;
   logic [TO_W-1:0] r_timer,    w_timer;
   logic            r_is_rd,    w_is_rd;
   logic            r_err,      w_err;
   sfr_word_t       r_bus,      w_bus;
   logic            r_req_ready, w_req_ready;
   logic            r_sfr_put,  w_put;
   logic            r_sfr_get,  w_get;
   logic            r_rsp_valid, w_rsp_valid;
   logic            r_rsp_err,  w_rsp_err;
   logic [7:0]      r_rsp_data, w_rsp_data;
   logic            r_rsp_bit,  w_rsp_bit;
   logic [7:0]      r_drop_cnt, w_drop_cnt;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; a missing default here would infer a latch.
      w_state     = r_state;
      w_timer     = r_timer;
      w_is_rd     = r_is_rd;
      w_err       = r_err;
      w_bus       = r_bus;
      w_put       = 1'b0;
      w_get       = 1'b0;
      w_rsp_valid = 1'b0;
      w_rsp_err   = 1'b0;
      w_rsp_data  = r_rsp_data;
      w_rsp_bit   = r_rsp_bit;
      w_drop_cnt  = r_drop_cnt;

      case (r_state)
         S_IDLE: begin
            // Any response seen while idle belongs to an abandoned read.
            // r_sfr_get guards against popping the same entry twice while the
            // synchroniser's rrdy has not yet dropped.
            if (sfr_rrdy && !r_sfr_get) begin
               w_get = 1'b1;
               if (r_drop_cnt != 8'hFF) w_drop_cnt = r_drop_cnt + 8'd1;
            end
            if (req_valid && r_req_ready) begin
               w_err   = req_wr && req_rd;
               w_is_rd = req_rd && !req_wr;
               if (req_wr || req_rd) begin
                  w_state = S_PUT;
                  // A drain pop in flight wins; the push follows next cycle.
                  w_put   = sfr_wrdy && !w_get;
                  if (req_wr) begin
                     w_bus = '{wr: 1'b1, rd: 1'b0, wr_bit: req_bit, rd_bit: 1'b0,
                               wr_addr: req_addr, rd_addr: IDLE_ADDR,
                               data: req_wdata, wbit: req_wbit};
                  end else begin
                     w_bus = '{wr: 1'b0, rd: 1'b1, wr_bit: 1'b0, rd_bit: req_bit,
                               wr_addr: IDLE_ADDR, rd_addr: req_addr,
                               data: 8'h00, wbit: 1'b0};
                  end
               end else begin
                  w_state     = S_DONE;
                  w_rsp_valid = 1'b1;
               end
            end
         end

         S_PUT: begin
            // r_sfr_put high means the push is happening in this cycle.
            if (r_sfr_put) begin
               if (r_is_rd) begin
                  w_state = S_WAIT;
                  w_timer = '0;
               end else begin
                  w_state     = S_DONE;
                  w_rsp_valid = 1'b1;
                  w_rsp_err   = r_err;
               end
            end else begin
               w_put = sfr_wrdy;
            end
         end

         S_WAIT: begin
            if (r_sfr_get) begin
               // Pop cycle: data_out/bit_out are driven by the synchroniser now.
               w_rsp_data  = data_out;
               w_rsp_bit   = bit_out;
               w_state     = S_DONE;
               w_rsp_valid = 1'b1;
               w_rsp_err   = r_err;
            end else if (sfr_rrdy) begin
               w_get = 1'b1;
            end else if (r_timer == TO_W'(TIMEOUT)) begin
               w_rsp_data  = 8'h00;
               w_rsp_bit   = 1'b0;
               w_state     = S_DONE;
               w_rsp_valid = 1'b1;
               w_rsp_err   = 1'b1;
            end else begin
               w_timer = r_timer + 1'b1;
            end
         end

         S_DONE: begin
            w_bus   = IDLE_WORD;
            w_err   = 1'b0;
            w_is_rd = 1'b0;
            w_state = S_IDLE;
         end

         default: begin
            w_bus   = IDLE_WORD;
            w_state = S_IDLE;
         end
      endcase

      w_req_ready = (w_state == S_IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge (synchronous); req_ready is
      // forced low while rst is asserted and rises on the first released edge.
      if (!rst) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_is_rd     <= 1'b0;
         r_err       <= 1'b0;
         r_bus       <= IDLE_WORD;
         r_req_ready <= 1'b0;
         r_sfr_put   <= 1'b0;
         r_sfr_get   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= 8'h00;
         r_rsp_bit   <= 1'b0;
         r_drop_cnt  <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values of the previous cycle, independent of statement order.
         r_state     <= w_state;
         r_timer     <= w_timer;
         r_is_rd     <= w_is_rd;
         r_err       <= w_err;
         r_bus       <= w_bus;
         r_req_ready <= w_req_ready;
         r_sfr_put   <= w_put;
         r_sfr_get   <= w_get;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_err   <= w_rsp_err;
         r_rsp_data  <= w_rsp_data;
         r_rsp_bit   <= w_rsp_bit;
         r_drop_cnt  <= w_drop_cnt;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_data  = r_rsp_data;
   assign rsp_bit   = r_rsp_bit;
   assign sfr_bus   = r_bus;
   assign sfr_put   = r_sfr_put;
   assign sfr_get   = r_sfr_get;
   assign drop_cnt  = r_drop_cnt;

endmodule
